// File: rtl/risk_tile_mem.sv
// Strided TILE x TILE register-tile load/store over BANKS single-port banks.
// Bank conflicts are split into one pass per cycle; same-address loads share a read.
module risk_tile_mem #(
  parameter int ELEM_W     = 18,
  parameter int TILE       = 4,
  parameter int BANKS      = 128,
  parameter int BANK_DEPTH = 1024,
  parameter int ADDR_W     = 17,
  parameter int STRIDE_W   = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [STRIDE_W-1:0]           req_stride_x,
  input  logic [STRIDE_W-1:0]           req_stride_y,
  input  logic [TILE*TILE*ELEM_W-1:0]   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [TILE*TILE*ELEM_W-1:0]   resp_rdata,
  output logic [$clog2(TILE*TILE):0]    resp_passes
);

  // state | meaning
  // IDLE  | waiting for a request
  // ISSUE | one bank pass per cycle until no element is pending
  // DRAIN | last load pass read data lands in the result register
  // RESP  | response held until resp_ready
  localparam int N       = TILE * TILE;
  localparam int BANK_AW = $clog2(BANKS);
  localparam int ROW_AW  = $clog2(BANK_DEPTH);
  localparam int PASS_W  = $clog2(N) + 1;
  localparam int DATA_W  = N * ELEM_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q [N];
  logic [ADDR_W-1:0]   addr_calc [N];
  logic [DATA_W-1:0]   wdata_q;
  logic [N-1:0]        pend_q, pend_d;
  logic [N-1:0]        svc_q, svc_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [N-1:0]        sel, svc;
  logic                accept;

  logic [BANKS-1:0]    bank_en;
  logic [ROW_AW-1:0]   bank_row [BANKS];
  logic [ELEM_W-1:0]   bank_wd  [BANKS];
  logic [ELEM_W-1:0]   bank_rd  [BANKS];

  assign req_ready   = (state_q == S_IDLE) && !reset;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_passes = passes_q;

  // Element addresses wrap modulo 2^ADDR_W.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      addr_calc[k] = ADDR_W'(32'(req_addr) + 32'(k % TILE) * 32'(req_stride_x)
                             + 32'(k / TILE) * 32'(req_stride_y));
    end
  end

  // sel: lowest pending element per bank. svc: elements completed this pass.
  always_comb begin
    sel = '0;
    svc = '0;
    for (int k = 0; k < N; k++) begin
      sel[k] = pend_q[k];
      for (int j = 0; j < k; j++) begin
        if (pend_q[j] && (addr_q[j][BANK_AW-1:0] == addr_q[k][BANK_AW-1:0])) sel[k] = 1'b0;
      end
    end
    svc = sel;
    if (!we_q) begin
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          if (sel[j] && pend_q[k] && (addr_q[j] == addr_q[k])) svc[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bank_en = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_row[b] = '0;
      bank_wd[b]  = '0;
    end
    if ((state_q == S_ISSUE) && !reset) begin
      for (int k = 0; k < N; k++) begin
        if (sel[k]) begin
          bank_en[addr_q[k][BANK_AW-1:0]]  = 1'b1;
          bank_row[addr_q[k][BANK_AW-1:0]] = addr_q[k][ADDR_W-1:BANK_AW];
          bank_wd[addr_q[k][BANK_AW-1:0]]  = wdata_q[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [ELEM_W-1:0] mem [BANK_DEPTH];
    logic [ELEM_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (bank_en[b]) begin
        if (we_q) mem[bank_row[b]] <= bank_wd[b];
        else      rd_q <= mem[bank_row[b]];
      end
    end
    assign bank_rd[b] = rd_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if ((pend_q & ~svc) == '0) state_d = S_DRAIN;
      S_DRAIN: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d   = pend_q;
    svc_d    = '0;
    rdata_d  = rdata_q;
    passes_d = passes_q;
    // svc_q marks elements whose bank read was issued last cycle.
    for (int k = 0; k < N; k++) begin
      if (svc_q[k]) rdata_d[k*ELEM_W +: ELEM_W] = bank_rd[addr_q[k][BANK_AW-1:0]];
    end
    if (accept) begin
      pend_d   = '1;
      rdata_d  = '0;
      passes_d = '0;
    end else if (state_q == S_ISSUE) begin
      pend_d   = pend_q & ~svc;
      passes_d = passes_q + PASS_W'(1);
      if (!we_q) svc_d = svc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      svc_q    <= '0;
      rdata_q  <= '0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      svc_q    <= svc_d;
      rdata_q  <= rdata_d;
      passes_q <= passes_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      wdata_q <= req_wdata;
      for (int k = 0; k < N; k++) addr_q[k] <= addr_calc[k];
    end
  end

endmodule

// File: tb/tb_risk_tile_mem.sv
// Self-checking bench for risk_tile_mem against a flat-array memory model.
module tb_risk_tile_mem;
  localparam int N  = 16;
  localparam int EW = 18;
  localparam int AW = 17;
  localparam int SW = 15;
  localparam int DW = N * EW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_stride_x, req_stride_y;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [4:0]    resp_passes;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [EW-1:0] mdl [0:(1<<AW)-1];

  risk_tile_mem dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_stride_x(req_stride_x), .req_stride_y(req_stride_y),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_passes(resp_passes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int ea(input int base, input int sx, input int sy, input int k);
    return (base + (k % 4) * sx + (k / 4) * sy) % (1 << AW);
  endfunction

  // Stores need one pass per element in the busiest bank; loads one per distinct address.
  function automatic int exp_passes(input bit we, input int base, input int sx, input int sy);
    int cnt [128];
    int a   [N];
    int best;
    bit dup;
    best = 0;
    for (int b = 0; b < 128; b++) cnt[b] = 0;
    for (int k = 0; k < N; k++) begin
      a[k] = ea(base, sx, sy, k);
      dup = 1'b0;
      if (!we) for (int j = 0; j < k; j++) if (a[j] == a[k]) dup = 1'b1;
      if (!dup) cnt[a[k] % 128]++;
    end
    for (int b = 0; b < 128; b++) if (cnt[b] > best) best = cnt[b];
    return best;
  endfunction

  task automatic model_store(input int base, input int sx, input int sy, input logic [DW-1:0] wd);
    for (int k = 0; k < N; k++) mdl[ea(base, sx, sy, k)] = wd[k*EW +: EW];
  endtask

  function automatic logic [DW-1:0] model_load(input int base, input int sx, input int sy);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*EW +: EW] = mdl[ea(base, sx, sy, k)];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*EW +: EW] = EW'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] seq_data();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*EW +: EW] = EW'(k + 1);
    return r;
  endfunction

  task automatic set_req(input bit we, input int base, input int sx, input int sy, input logic [DW-1:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = AW'(base);
    req_stride_x = SW'(sx);
    req_stride_y = SW'(sy);
    req_wdata    = wd;
  endtask

  // Issues one request and completes the handshake as soon as the response appears.
  task automatic run_req(input bit we, input int base, input int sx, input int sy,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                         output int ps, output int lat, output int acc);
    int n;
    set_req(we, base, sx, sy, wd);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL run_req_ready_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin
      tests++; fails++;
      $display("FAIL run_req_resp_timeout got=0 exp=1");
    end
    lat = cyc - acc + 1;
    rd  = resp_rdata;
    ps  = int'(resp_passes);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic chk_load(input string nm, input int base, input int sx, input int sy);
    logic [DW-1:0] rd, ex;
    int ps, lat, acc, ep;
    ex = model_load(base, sx, sy);
    ep = exp_passes(1'b0, base, sx, sy);
    run_req(1'b0, base, sx, sy, '0, rd, ps, lat, acc);
    tests++; if (rd !== ex) begin fails++; $display("FAIL %s_data got=%h exp=%h", nm, rd, ex); end
    tests++; if (ps !== ep) begin fails++; $display("FAIL %s_passes got=%0d exp=%0d", nm, ps, ep); end
    tests++; if (lat !== ep + 2) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, ep + 2); end
  endtask

  task automatic chk_store(input string nm, input int base, input int sx, input int sy, input logic [DW-1:0] wd);
    logic [DW-1:0] rd;
    int ps, lat, acc, ep;
    ep = exp_passes(1'b1, base, sx, sy);
    run_req(1'b1, base, sx, sy, wd, rd, ps, lat, acc);
    model_store(base, sx, sy, wd);
    tests++; if (rd !== '0) begin fails++; $display("FAIL %s_rdata_zero got=%h exp=0", nm, rd); end
    tests++; if (ps !== ep) begin fails++; $display("FAIL %s_passes got=%0d exp=%0d", nm, ps, ep); end
    tests++; if (lat !== ep + 2) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, ep + 2); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    tests++; if (resp_rdata !== '0) begin fails++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    tests++; if (resp_passes !== 5'd0) begin fails++; $display("FAIL reset_resp_passes got=%0d exp=0", resp_passes); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_basic();
    chk_store("basic_store", 0, 1, 4, seq_data());
    chk_load("basic_load", 0, 1, 4);
  endtask

  task automatic test_conflict();
    chk_store("conflict_store", 5, 128, 512, rand_data());
    chk_load("conflict_load", 5, 128, 512);
  endtask

  task automatic test_merge();
    chk_load("merge_load", 9, 0, 0);
  endtask

  task automatic test_dup_store();
    logic [DW-1:0] rd;
    int ps, lat, acc;
    chk_store("dup_store", 7, 0, 0, seq_data());
    run_req(1'b0, 7, 0, 0, '0, rd, ps, lat, acc);
    tests++; if (rd[15*EW +: EW] !== 18'd16 || rd !== model_load(7, 0, 0)) begin
      fails++; $display("FAIL dup_load_data got=%h exp=all 16", rd);
    end
    tests++; if (ps !== 1) begin fails++; $display("FAIL dup_load_passes got=%0d exp=1", ps); end
  endtask

  task automatic test_wrap();
    chk_store("wrap_store", 'h1FFFF, 1, 0, rand_data());
    chk_load("wrap_load", 'h1FFFF, 1, 0);
  endtask

  task automatic test_reset_mid();
    int n, seen;
    set_req(1'b0, 5, 128, 512, '0);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready_in_reset got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready_after got=%b exp=1", req_ready); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_resp_valid got=%0d cycles exp=0", seen); end
    chk_load("midreset_followup", 0, 1, 4);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rd0, bogus;
    int n, seen;
    set_req(1'b0, 0, 1, 4, '0);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    rd0 = resp_rdata;
    tests++; if (rd0 !== model_load(0, 1, 4)) begin fails++; $display("FAIL bp_data got=%h exp=%h", rd0, model_load(0, 1, 4)); end
    bogus = rand_data();
    set_req(1'b1, 0, 1, 4, bogus);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_hold i=%0d got=%b exp=1", i, resp_valid); end
      tests++; if (resp_rdata !== rd0) begin fails++; $display("FAIL bp_data_hold i=%0d got=%h exp=%h", i, resp_rdata, rd0); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low i=%0d got=%b exp=0", i, req_ready); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after got=%b exp=1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL bp_ignored_req got=%0d resp cycles exp=0", seen); end
    chk_load("bp_reload", 0, 1, 4);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd;
    int ps1, lat1, acc1, ps2, lat2, acc2, ep;
    ep = exp_passes(1'b0, 5, 128, 512);
    run_req(1'b0, 5, 128, 512, '0, rd, ps1, lat1, acc1);
    run_req(1'b0, 0, 1, 4, '0, rd, ps2, lat2, acc2);
    tests++; if (acc2 - acc1 !== ep + 3) begin fails++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc2 - acc1, ep + 3); end
    tests++; if (rd !== model_load(0, 1, 4)) begin fails++; $display("FAIL b2b_data got=%h exp=%h", rd, model_load(0, 1, 4)); end
  endtask

  task automatic test_random();
    int base, sx, sy, mode;
    for (int it = 0; it < 12; it++) begin
      base = $urandom_range(0, (1 << AW) - 1);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       begin sx = $urandom_range(0, 3);          sy = $urandom_range(0, 3); end
        1:       begin sx = 128 * $urandom_range(0, 255);  sy = 128 * $urandom_range(0, 255); end
        2:       begin sx = $urandom_range(0, 32767);      sy = $urandom_range(0, 32767); end
        default: begin sx = $urandom_range(0, 7);          sy = 0; end
      endcase
      chk_store("rand_store", base, sx, sy, rand_data());
      chk_load("rand_load", base, sx, sy);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_stride_x = '0;
    req_stride_y = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    test_reset();
    test_basic();
    test_conflict();
    test_merge();
    test_dup_store();
    test_wrap();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/risk_tile_mem.md
Name: risk_tile_mem

Overview:
Parametrised successor to the RISK strided register-tile memory. It loads or stores one TILE x TILE tile of ELEM_W-bit elements at addresses base + x*stride_x + y*stride_y across BANKS single-port BRAM banks. Bank conflicts are detected and serialised over multiple passes by a small FSM, so any stride is legal. It sits between the RISK register file and the banked scratchpad, with valid/ready handshakes on both request and response.

Parameters:
ELEM_W, 18, element width in bits
TILE, 4, tile edge; tile holds N = TILE*TILE elements
BANKS, 128, bank count; power of two
BANK_DEPTH, 1024, words per bank; power of two
ADDR_W, 17, element address width; must equal log2(BANKS*BANK_DEPTH)
STRIDE_W, 15, stride width, unsigned

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  block idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  base element address
req_stride_x  in  STRIDE_W  element stride along x
req_stride_y  in  STRIDE_W  element stride along y
req_wdata  in  N*ELEM_W  store data; element k=y*TILE+x at bits [k*ELEM_W +: ELEM_W]
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_rdata  out  N*ELEM_W  load data, same packing; all zero for stores
resp_passes  out  log2(N)+1  number of bank passes used (P)

Behaviour:
- Clock port is clk. Reset is synchronous and active-high, named reset.
- Reset values: req_ready=0 while reset is high and 1 from the first cycle after; resp_valid=0, resp_rdata=0, resp_passes=0. Reset mid-operation returns to IDLE and drops any pending response. Bank writes already issued stay in memory; unissued writes are lost.
- Address: a_k = (req_addr + x*stride_x + y*stride_y) mod 2^ADDR_W, with silent wrap-around. bank_k = a_k[log2(BANKS)-1:0], row_k = a_k >> log2(BANKS).
- Accept on req_valid && req_ready, in cycle T. Request fields and all a_k are registered at end of T, and the pending mask is set to all-ones. req_ready stays low until the response handshake completes.
- FSM states:
  - IDLE -> ISSUE on accept.
  - ISSUE: one pass per cycle. For each bank, select the lowest-index pending element mapped to that bank.
    - Load: also service every other pending element with the same full address (merge). Clear their pending bits.
    - Store: write the selected element only. Duplicate addresses are therefore written in ascending k, so the highest k wins.
    - ISSUE -> DRAIN when the pending mask becomes zero after the pass.
  - DRAIN: one cycle, capturing BRAM output of the last load pass. For stores, no capture.
  - DRAIN -> RESP.
  - RESP: resp_valid=1, and resp_rdata/resp_passes are held stable until resp_ready. RESP -> IDLE on resp_ready; req_ready=1 from the next cycle.
- Pass k is issued in cycle T+k, for k=1..P. Load data for pass k is captured into the result register at the end of cycle T+k+1.
- Latency: first resp_valid cycle is T+P+2 for both loads and stores (conflict-free P=1 gives T+3). P ranges from 1 to N.
- Banks: single-port BRAM with one-cycle registered read. Write and read are exclusive per cycle; no read-during-write output is used.
- resp_ready held high: back-to-back requests have a minimum spacing of P+3 cycles.
- req_valid while req_ready=0 is ignored (not queued).

Test Plan:
1. Store addr=0, sx=1, sy=4, element k = k+1 -> resp_passes=1, resp_valid at T+3. Then load with the same params -> resp_rdata elements 1..16 in order, passes=1.
2. Load addr=5, sx=128, sy=512 -> all 16 elements hit bank 5 at distinct rows, so passes=16 and resp_valid at T+18. Data matches preloaded rows 0..15 of bank 5 (rows r = x + 4y).
3. Load sx=0, sy=0, addr=9 -> all addresses identical and merged: passes=1, all 16 elements equal mem[9].
4. Store sx=0, sy=0, addr=7, element k = k+1 -> passes=16. Then load addr=7, sx=sy=0 -> every element = 16.
5. Load addr=0x1FFFF, sx=1, sy=0 -> element 0 from 0x1FFFF (bank 127, row 1023); element 1 from 0x00000 (bank 0, row 0); passes=1.
6. Reset at T+5 during the case-2 load -> resp_valid never rises; req_ready=1 one cycle after reset drops. A following case-1 load completes with correct data.
7. Hold resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_rdata stay stable, req_ready=0, and a new req_valid is ignored until the response handshake completes.
